cpu_data_confreg_bridge: RTL

- Sits directly downstream of the CPU data SRAM port and consumes every data access the EXE stage issues.
- Decodes each access to either the external data RAM (passthrough) or a local block of configuration registers: LED, switch, free-running timer, four scratch registers, simulation flag.
- Keeps the CPU-visible contract unchanged: fixed 1-cycle read latency, byte-enable writes.

---
 rtl/cpu_data_confreg_bridge.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cpu_data_confreg_bridge.sv
// Splits CPU data accesses between external RAM (passthrough) and a local
// confreg block: LED, switches, free-running timer, scratch and SIMU flag.
module cpu_data_confreg_bridge #(
  parameter logic [31:0] CONF_BASE = 32'hBFAF_0000,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned SW_W      = 8,
  parameter logic [31:0] SIMU_FLAG = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cpu_en,
  input  logic [3:0]       cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             ram_en,
  output logic [3:0]       ram_we,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata,
  input  logic [SW_W-1:0]  switch_in,
  output logic [LED_W-1:0] led_out
);

  typedef enum logic [3:0] {
    SEL_LED, SEL_SWITCH, SEL_TIMER,
    SEL_SCR0, SEL_SCR1, SEL_SCR2, SEL_SCR3,
    SEL_SIMU, SEL_NONE
  } reg_sel_e;

  logic             hit;
  logic             wr;
  reg_sel_e         sel;
  logic [31:0]      rd_val;
  logic [31:0]      wr_val;

  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  sw_meta_q;
  logic [SW_W-1:0]  sw_sync_q;
  logic [31:0]      timer_q;
  logic [31:0]      scratch_q [4];
  logic             sel_conf_q;
  logic [31:0]      conf_rdata_q;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  assign hit = cpu_en && (cpu_addr[31:16] == CONF_BASE[31:16]);
  assign wr  = hit && (cpu_we != 4'b0000);

  assign ram_en    = cpu_en && !hit;
  assign ram_we    = hit ? 4'b0000 : cpu_we;
  assign ram_addr  = cpu_addr;
  assign ram_wdata = cpu_wdata;

  always_comb begin
    sel = SEL_NONE;
    if (cpu_addr[15:6] == 10'd0) begin
      case (cpu_addr[5:2])
        4'h0: sel = SEL_LED;
        4'h1: sel = SEL_SWITCH;
        4'h2: sel = SEL_TIMER;
        4'h4: sel = SEL_SCR0;
        4'h5: sel = SEL_SCR1;
        4'h6: sel = SEL_SCR2;
        4'h7: sel = SEL_SCR3;
        4'h8: sel = SEL_SIMU;
        default: sel = SEL_NONE;
      endcase
    end
  end

  // The current register value doubles as the base for byte-merged writes.
  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_LED:    rd_val[LED_W-1:0] = led_q;
      SEL_SWITCH: rd_val[SW_W-1:0]  = sw_sync_q;
      SEL_TIMER:  rd_val = timer_q;
      SEL_SCR0:   rd_val = scratch_q[0];
      SEL_SCR1:   rd_val = scratch_q[1];
      SEL_SCR2:   rd_val = scratch_q[2];
      SEL_SCR3:   rd_val = scratch_q[3];
      SEL_SIMU:   rd_val = SIMU_FLAG;
      default:    rd_val = '0;
    endcase
  end

  assign wr_val = merge_bytes(rd_val, cpu_wdata, cpu_we);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      timer_q   <= '0;
      for (int unsigned i = 0; i < 4; i++) scratch_q[i] <= '0;
    end else begin
      sw_meta_q <= switch_in;
      sw_sync_q <= sw_meta_q;
      if (wr && sel == SEL_TIMER) timer_q <= wr_val;
      else                        timer_q <= timer_q + 32'd1;
      if (wr) begin
        case (sel)
          SEL_LED:  led_q        <= wr_val[LED_W-1:0];
          SEL_SCR0: scratch_q[0] <= wr_val;
          SEL_SCR1: scratch_q[1] <= wr_val;
          SEL_SCR2: scratch_q[2] <= wr_val;
          SEL_SCR3: scratch_q[3] <= wr_val;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_conf_q   <= 1'b0;
      conf_rdata_q <= '0;
    end else if (cpu_en) begin
      sel_conf_q <= hit;
      if (hit) conf_rdata_q <= (cpu_we == 4'b0000) ? rd_val : '0;
    end
  end

  assign cpu_rdata = sel_conf_q ? conf_rdata_q : ram_rdata;
  assign led_out   = led_q;

endmodule
